// File: rtl/prbs_gen_chk_if.sv
// rtl/prbs_gen_chk_if.sv - Control, receive-word and status bundle for prbs_gen_chk
interface prbs_gen_chk_if #(
    parameter int WIDTH = 24,
    parameter int STEP  = 8,
    parameter int ERR_W = 16
);
    logic             EN;
    logic             SEED_LD;
    logic [WIDTH-1:0] SEED;
    logic             RX_VALID;
    logic [STEP-1:0]  RX_DATA;
    logic             CLR;
    logic [WIDTH-1:0] LFSR;
    logic [STEP-1:0]  PRBS_OUT;
    logic             LOCKED;
    logic             ERR_STB;
    logic [ERR_W-1:0] ERR_CNT;

    modport master (
        output EN, SEED_LD, SEED, RX_VALID, RX_DATA, CLR,
        input  LFSR, PRBS_OUT, LOCKED, ERR_STB, ERR_CNT
    );

    modport slave (
        input  EN, SEED_LD, SEED, RX_VALID, RX_DATA, CLR,
        output LFSR, PRBS_OUT, LOCKED, ERR_STB, ERR_CNT
    );
endinterface

// File: rtl/prbs_gen_chk.sv
// rtl/prbs_gen_chk.sv - Parallel Fibonacci PRBS generator with self-synchronising checker
module prbs_gen_chk #(
    parameter int               WIDTH     = 24,
    parameter logic [WIDTH-1:0] TAPS      = 24'hE10000,
    parameter int               STEP      = 8,
    parameter logic [WIDTH-1:0] INIT_FILL = 24'h4DB62E,
    parameter int               LOCK_CNT  = 16,
    parameter int               LOSS_CNT  = 8,
    parameter int               ERR_W     = 16
) (
    input logic           CLK,
    input logic           RST_N,
    prbs_gen_chk_if.slave bus
);
    localparam int         HUNT_WORDS = (WIDTH + STEP - 1) / STEP;
    localparam logic [7:0] HUNT_LAST  = 8'(HUNT_WORDS - 1);
    localparam logic [7:0] LOCK_LAST  = 8'(LOCK_CNT - 1);
    localparam logic [7:0] LOSS_LAST  = 8'(LOSS_CNT - 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Returns {state after STEP serial steps, emitted word with first bit at STEP-1}.
    function automatic logic [WIDTH+STEP-1:0] advance(input logic [WIDTH-1:0] s_in);
        logic [WIDTH-1:0] s;
        logic [STEP-1:0]  w;
        logic             fb;
        s = s_in;
        w = '0;
        for (int k = 0; k < STEP; k++) begin
            fb            = ^(s & TAPS);
            s             = {s[WIDTH-2:0], fb};
            w[STEP-1-k]   = fb;
        end
        return {s, w};
    endfunction

    logic [WIDTH-1:0] lfsr_q;
    logic [STEP-1:0]  prbs_q;
    logic [WIDTH-1:0] gen_next;
    logic [STEP-1:0]  gen_word;

    logic [WIDTH-1:0] pred_q;
    logic [WIDTH-1:0] pred_next;
    logic [STEP-1:0]  pred_word;
    logic [WIDTH-1:0] hunt_shift;
    state_t           state_q;
    logic [7:0]       word_cnt_q;
    logic [7:0]       match_cnt_q;
    logic [7:0]       loss_cnt_q;
    logic             locked_q;
    logic             err_stb_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic             word_ok;
    logic             word_err;

    assign {gen_next, gen_word}   = advance(lfsr_q);
    assign {pred_next, pred_word} = advance(pred_q);
    assign word_ok  = (pred_word == bus.RX_DATA);
    assign word_err = bus.RX_VALID && (state_q == ST_LOCKED) && !word_ok;

    generate
        if (STEP < WIDTH) begin : g_shift
            assign hunt_shift = {pred_q[WIDTH-1-STEP:0], bus.RX_DATA};
        end else begin : g_load
            assign hunt_shift = bus.RX_DATA;
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lfsr_q <= INIT_FILL;
            prbs_q <= '0;
        end else if (bus.SEED_LD) begin
            lfsr_q <= (bus.SEED == '0) ? INIT_FILL : bus.SEED;
        end else if (bus.EN) begin
            lfsr_q <= gen_next;
            prbs_q <= gen_word;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pred_q      <= INIT_FILL;
            state_q     <= ST_HUNT;
            word_cnt_q  <= '0;
            match_cnt_q <= '0;
            loss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            err_stb_q   <= 1'b0;
        end else begin
            err_stb_q <= 1'b0;
            if (bus.RX_VALID) begin
                case (state_q)
                    ST_HUNT: begin
                        pred_q <= hunt_shift;
                        if (word_cnt_q == HUNT_LAST) begin
                            state_q     <= ST_VERIFY;
                            word_cnt_q  <= '0;
                            match_cnt_q <= '0;
                        end else begin
                            word_cnt_q <= word_cnt_q + 8'd1;
                        end
                    end
                    ST_VERIFY: begin
                        pred_q <= pred_next;
                        // A zero predictor would "match" an idle all-zero line forever.
                        if (word_ok && (pred_q != '0)) begin
                            if (match_cnt_q == LOCK_LAST) begin
                                state_q    <= ST_LOCKED;
                                locked_q   <= 1'b1;
                                loss_cnt_q <= '0;
                            end else begin
                                match_cnt_q <= match_cnt_q + 8'd1;
                            end
                        end else begin
                            state_q    <= ST_HUNT;
                            word_cnt_q <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        pred_q <= pred_next;
                        if (word_ok) begin
                            loss_cnt_q <= '0;
                        end else begin
                            err_stb_q <= 1'b1;
                            if (loss_cnt_q == LOSS_LAST) begin
                                state_q    <= ST_HUNT;
                                locked_q   <= 1'b0;
                                word_cnt_q <= '0;
                                loss_cnt_q <= '0;
                            end else begin
                                loss_cnt_q <= loss_cnt_q + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state_q    <= ST_HUNT;
                        locked_q   <= 1'b0;
                        word_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_cnt_q <= '0;
        end else if (bus.CLR) begin
            err_cnt_q <= '0;
        end else if (word_err && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign bus.LFSR     = lfsr_q;
    assign bus.PRBS_OUT = prbs_q;
    assign bus.LOCKED   = locked_q;
    assign bus.ERR_STB  = err_stb_q;
    assign bus.ERR_CNT  = err_cnt_q;
endmodule

// File: doc/prbs_gen_chk.md
PRBS_GEN_CHK -- requirements
Module: prbs_gen_chk

Interface
REQ-001 Parameter WIDTH, 24, LFSR length in bits (8..64).
REQ-002 Parameter TAPS, 24'hE10000, feedback mask; bit i set means state bit i feeds the XOR.
REQ-003 Parameter STEP, 8, serial LFSR steps per clock (1..WIDTH).
REQ-004 Parameter INIT_FILL, 24'h4DB62E, reset and zero-substitute fill; SHALL be nonzero.
REQ-005 Parameter LOCK_CNT, 16, consecutive matching words needed to declare lock (1..255).
REQ-006 Parameter LOSS_CNT, 8, consecutive errored words that drop lock (1..255).
REQ-007 Parameter ERR_W, 16, error counter width.
REQ-008 CLK  in  1  single clock; all state changes on its rising edge.
REQ-009 RST_N  in  1  asynchronous, active-low reset.
REQ-010 EN  in  1  generator advance enable.
REQ-011 SEED_LD  in  1  load SEED into generator state.
REQ-012 SEED  in  WIDTH  generator seed value.
REQ-013 RX_VALID  in  1  RX_DATA word qualifier.
REQ-014 RX_DATA  in  STEP  received word; bit STEP-1 is the oldest bit.
REQ-015 CLR  in  1  synchronous clear of ERR_CNT.
REQ-016 LFSR  out  WIDTH  generator state.
REQ-017 PRBS_OUT  out  STEP  generated word; bit STEP-1 is the oldest bit.
REQ-018 LOCKED  out  1  checker in LOCKED state.
REQ-019 ERR_STB  out  1  one-cycle pulse per errored word while LOCKED.
REQ-020 ERR_CNT  out  ERR_W  saturating count of errored words.

Function
REQ-021 One serial step SHALL be: fb = XOR of state bits selected by TAPS; state <= {state[WIDTH-2:0], fb}; the emitted bit is fb.
REQ-022 On EN=1, the generator SHALL apply STEP serial steps in one clock: LFSR takes the final state, and PRBS_OUT takes the STEP emitted bits, first emitted in bit STEP-1; outputs are registered, with latency 1 clock.
REQ-023 On EN=0, LFSR and PRBS_OUT SHALL hold.
REQ-024 SEED_LD SHALL have priority over EN: LFSR<=SEED, PRBS_OUT holds, and no step is taken that cycle.
REQ-025 If SEED is all zeros, LFSR SHALL load INIT_FILL instead.
REQ-026 The checker SHALL hold its own WIDTH-bit predictor register, independent of the generator.
REQ-027 Checker states: HUNT, VERIFY, LOCKED.
- State advances only on cycles with RX_VALID=1.
- Cycles with RX_VALID=0 leave all checker state unchanged.
REQ-028 HUNT: on each valid word, predictor <= {predictor[WIDTH-1-STEP:0], RX_DATA}; after ceil(WIDTH/STEP) valid words the checker SHALL move to VERIFY, with the match counter cleared.
REQ-029 VERIFY: on each valid word, the predictor advances STEP steps and the emitted word is compared to RX_DATA.
- Match: increment the match counter.
- Mismatch: go to HUNT and clear the word counter.
- LOCK_CNT consecutive matches: go to LOCKED.
REQ-030 LOCKED: on each valid word, the predictor advances by prediction only (RX_DATA is never loaded).
- Any bit mismatch SHALL pulse ERR_STB in the next cycle, increment ERR_CNT and increment the loss counter.
- A matching word clears the loss counter.
REQ-031 LOSS_CNT consecutive errored words SHALL move the checker to HUNT and deassert LOCKED on the next clock; ERR_CNT is retained.
REQ-032 ERR_CNT SHALL saturate at 2^ERR_W-1.
REQ-033 CLR SHALL zero ERR_CNT next cycle; a simultaneous error is discarded; CLR does not affect the state machine.
REQ-034 An all-zero predictor on entry to VERIFY SHALL be treated as a mismatch (return to HUNT).
REQ-035 The generator and checker are independent; MODE-free operation, and both run concurrently.

Reset
REQ-036 With RST_N=0, asynchronously:
- LFSR=INIT_FILL, PRBS_OUT=0.
- predictor=INIT_FILL, state=HUNT, all internal counters=0.
- LOCKED=0, ERR_STB=0, ERR_CNT=0.
REQ-037 Reset asserted mid-lock SHALL abandon lock immediately; after release the checker restarts in HUNT.

Verification
REQ-038 Reset release, EN=1 for 1 clock (defaults) -> LFSR and PRBS_OUT equal 8 steps of a golden serial model from 24'h4DB62E; repeat for 1000 clocks -> continuous match.
REQ-039 SEED_LD=1, SEED=0, EN=1 -> LFSR=24'h4DB62E, PRBS_OUT unchanged; SEED=24'h000001 -> LFSR=24'h000001.
REQ-040 Loopback PRBS_OUT->RX_DATA with RX_VALID=EN continuously -> LOCKED rises on the clock after valid word 3+16=19; ERR_CNT stays 0.
REQ-041 Locked, flip 1 bit of one word -> ERR_STB high exactly 1 cycle, ERR_CNT=1, LOCKED stays 1; 8 consecutive corrupted words -> LOCKED=0, ERR_CNT=9, relock after a further 19 clean words.
REQ-042 ERR_W=4, locked, corrupt every other word for 40 words -> ERR_CNT=15 held, LOCKED=1; CLR pulse -> ERR_CNT=0.
REQ-043 STEP=1 and STEP=WIDTH builds, plus a WIDTH=31 build with TAPS=31'h48000000 -> output matches the golden model for 2^16 bits; RX_VALID gaps of random length -> no false errors.
